async_clk_period_meter: RTL and testbench

Measures the period of an asynchronous clock in units of the system clock `syn_clk`. It sits directly downstream of the team's synchronous/asynchronous clock generators. The input clock is resynchronised, its rising edges are detected, and the `syn_clk` cycles between consecutive rising edges are counted. Per-edge period samples are reported with a valid pulse, along with running min/max statistics and a sticky overflow flag.

---
 rtl/clk_meas_pkg.sv | 13 +
 rtl/sync_edge_detect.sv | 27 ++
 rtl/async_clk_period_meter.sv | 137 +++++++++++++
 tb/tb_async_clk_period_meter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock-period measurement blocks.
package clk_meas_pkg;

    localparam int DEFAULT_CNT_W = 16;
    localparam logic [DEFAULT_CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } meas_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Resynchronises an asynchronous level into syn_clk and flags its rising edges.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic syn_clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    // Legal SYNC_STAGES range is 2 to 4; stage 0 is the metastability catcher.
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge syn_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/async_clk_period_meter.sv
// Counts syn_clk cycles between rising edges of an asynchronous clock and
// keeps per-sample output plus running min/max and a sticky overflow flag.
module async_clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             syn_clk,
    input  logic             rst_n,
    input  logic             asyn_clk_in,
    input  logic             en,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period,
    output logic             overflow,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    meas_state_e      r_state;
    meas_state_e      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_rise;
    logic             w_sample;
    logic             w_ovf_evt;

    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;
    logic             r_overflow;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .syn_clk  (syn_clk),
        .rst_n    (rst_n),
        .async_in (asyn_clk_in),
        .rise     (w_rise)
    );

    always_ff @(posedge syn_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Disable has priority over everything, so a partial period is simply dropped.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sample     = 1'b0;
        w_ovf_evt    = 1'b0;
        if (!en) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = ARM;
                    w_cnt_next   = '0;
                end
                ARM: begin
                    if (w_rise) begin
                        w_state_next = MEASURE;
                        w_cnt_next   = ONE;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        w_sample   = 1'b1;
                        w_cnt_next = ONE;
                    end else if (r_cnt == ALL_ONES) begin
                        w_ovf_evt    = 1'b1;
                        w_state_next = ARM;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + ONE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge syn_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_min          <= ALL_ONES;
            r_max          <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_period_valid <= w_sample;
            if (w_sample) begin
                r_period <= r_cnt;
            end
            // A sample arriving with a clear restarts the statistics from that sample.
            if (w_sample && clr_stats) begin
                r_min <= r_cnt;
                r_max <= r_cnt;
            end else if (clr_stats) begin
                r_min <= ALL_ONES;
                r_max <= '0;
            end else if (w_sample) begin
                if (r_cnt < r_min) begin
                    r_min <= r_cnt;
                end
                if (r_cnt > r_max) begin
                    r_max <= r_cnt;
                end
            end
            r_overflow <= w_ovf_evt | (r_overflow & ~clr_stats);
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign min_period   = r_min;
    assign max_period   = r_max;
    assign overflow     = r_overflow;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_async_clk_period_meter.sv
// Bench for async_clk_period_meter: a 16-bit and a 4-bit instance share stimulus;
// expected samples come from the distance between driven rising edges.
module tb_async_clk_period_meter;

    localparam int LAT = 3;   // drive edge -> registered sample, with edges placed 2 ns after syn_clk

    logic        syn_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        asyn    = 1'b0;
    logic        en      = 1'b0;
    logic        clr     = 1'b0;

    logic [15:0] p16, mn16, mx16;
    logic        v16, ov16, b16;
    logic [3:0]  p4, mn4, mx4;
    logic        v4, ov4, b4;

    async_clk_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut16 (
        .syn_clk(syn_clk), .rst_n(rst_n), .asyn_clk_in(asyn), .en(en), .clr_stats(clr),
        .period(p16), .period_valid(v16), .min_period(mn16), .max_period(mx16),
        .overflow(ov16), .busy(b16)
    );

    async_clk_period_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .syn_clk(syn_clk), .rst_n(rst_n), .asyn_clk_in(asyn), .en(en), .clr_stats(clr),
        .period(p4), .period_valid(v4), .min_period(mn4), .max_period(mx4),
        .overflow(ov4), .busy(b4)
    );

    always #5 syn_clk = ~syn_clk;

    typedef struct {
        int due;
        int val;
    } exp_t;

    typedef struct {
        int hi;
        int lo;
        int reps;
        bit clr;
        int ep;
        int emin;
        int emax;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    exp_t cur;
    int   ecnt = 0;
    int   last_rise = 0;
    bit   armed = 1'b0;
    bit   prev_a = 1'b0;
    int   mmin = 65535;
    int   mmax = 0;
    bit   chk4 = 1'b1;
    bit   clr_q = 1'b0;
    bit   exp_v;
    int   vcnt16 = 0;
    int   vcnt4 = 0;
    vec_t tv[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One syn_clk cycle of stimulus; every driven rise while enabled is one period boundary.
    task automatic tick(input bit a, input bit e = 1'b1, input bit c = 1'b0);
        @(posedge syn_clk);
        #2;
        asyn = a;
        en   = e;
        clr  = c;
        if (a && !prev_a) begin
            if (e && armed) q.push_back(exp_t'{due: ecnt + LAT, val: ecnt - last_rise});
            if (e) begin
                armed     = 1'b1;
                last_rise = ecnt;
            end
        end
        if (!e) armed = 1'b0;
        prev_a = a;
    endtask

    task automatic wave(input int hi, input int lo, input int clr_at = -1);
        for (int i = 0; i < hi + lo; i++) tick(i < hi, 1'b1, i == clr_at);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_period16"}, p16, 0);
        chk({tag, "_valid16"}, v16, 0);
        chk({tag, "_min16"}, mn16, 16'hFFFF);
        chk({tag, "_max16"}, mx16, 0);
        chk({tag, "_ovf16"}, ov16, 0);
        chk({tag, "_busy16"}, b16, 0);
        chk({tag, "_period4"}, p4, 0);
        chk({tag, "_min4"}, mn4, 4'hF);
        chk({tag, "_max4"}, mx4, 0);
        chk({tag, "_busy4"}, b4, 0);
    endtask

    always @(posedge syn_clk) begin
        ecnt  <= ecnt + 1;
        clr_q <= clr;
    end

    // Scoreboard: a sample is due LAT edges after its closing rise; stats follow min/max rules.
    always @(negedge syn_clk) begin
        if (rst_n) begin
            exp_v = (q.size() > 0) && (q[0].due == ecnt);
            if (clr_q) begin
                mmin = 65535;
                mmax = 0;
            end
            if (exp_v) begin
                cur = q.pop_front();
                if (cur.val < mmin) mmin = cur.val;
                if (cur.val > mmax) mmax = cur.val;
            end
            if (v16) vcnt16++;
            if (v4) vcnt4++;
            if (v16 || exp_v) chk("valid16", v16, exp_v);
            if (exp_v) begin
                chk("period16", p16, cur.val);
                chk("min16", mn16, mmin);
                chk("max16", mx16, mmax);
            end
            if (chk4 && (v4 || exp_v)) chk("valid4", v4, exp_v);
            if (chk4 && exp_v) begin
                chk("period4", p4, cur.val);
                chk("min4", mn4, mmin);
                chk("max4", mx4, mmax);
            end
        end
    end

    initial begin
        int s16, s4, hi, lo, ca;
        tv[0] = '{4, 4, 4, 1'b1, 8, 8, 8};
        tv[1] = '{3, 2, 4, 1'b0, 5, 5, 8};
        tv[2] = '{5, 5, 4, 1'b1, 10, 10, 10};
        tv[3] = '{2, 2, 4, 1'b0, 4, 4, 10};
        tv[4] = '{7, 6, 4, 1'b0, 13, 4, 13};

        repeat (3) tick(1'b0, 1'b0, 1'b0);
        chk_reset("reset");
        #1 rst_n = 1'b1;
        repeat (4) tick(1'b0);
        chk("busy_armed", b16, 1);

        // Steady waveforms
        for (int i = 0; i < 5; i++) begin
            for (int r = 0; r < tv[i].reps; r++)
                wave(tv[i].hi, tv[i].lo, (r == 0 && tv[i].clr) ? 4 : -1);
            chk($sformatf("tbl%0d_period16", i), p16, tv[i].ep);
            chk($sformatf("tbl%0d_min16", i), mn16, tv[i].emin);
            chk($sformatf("tbl%0d_max16", i), mx16, tv[i].emax);
            chk($sformatf("tbl%0d_period4", i), p4, tv[i].ep);
            chk($sformatf("tbl%0d_min4", i), mn4, tv[i].emin);
            chk($sformatf("tbl%0d_max4", i), mx4, tv[i].emax);
            chk($sformatf("tbl%0d_ovf16", i), ov16, 0);
        end

        // Clear on the same cycle as a sample
        wave(3, 2, 4);
        wave(5, 4);
        wave(4, 3);
        chk("pre_clr_min16", mn16, 5);
        chk("pre_clr_max16", mx16, 9);
        wave(2, 2, 2);
        chk("clr_sample_period16", p16, 7);
        chk("clr_sample_min16", mn16, 7);
        chk("clr_sample_max16", mx16, 7);
        chk("clr_sample_min4", mn4, 7);
        chk("clr_sample_max4", mx4, 7);

        // Randomised periods with occasional clears
        repeat (40) begin
            hi = $urandom_range(1, 7);
            lo = $urandom_range(1, 7);
            ca = ($urandom_range(0, 3) == 0) ? $urandom_range(0, hi + lo - 1) : -1;
            wave(hi, lo, ca);
        end

        // Disable mid-period
        wave(4, 4);
        wave(4, 4);
        for (int i = 0; i < 8; i++) begin
            tick(i < 4, !(i >= 4 && i <= 6), 1'b0);
            if (i == 4) begin
                s16 = vcnt16;
                s4  = vcnt4;
            end
            if (i == 5) begin
                chk("dis_busy16", b16, 0);
                chk("dis_period_held16", p16, 8);
            end
        end
        wave(4, 4);
        chk("dis_no_sample16", vcnt16, s16);
        chk("dis_no_sample4", vcnt4, s4);
        wave(4, 4);
        chk("dis_resume16", vcnt16, s16 + 1);
        chk("dis_resume_period16", p16, 8);

        // Asynchronous reset mid-measurement
        wave(4, 4);
        tick(1'b1);
        tick(1'b1);
        #1 rst_n = 1'b0;
        #1 chk_reset("async_rst");
        q.delete();
        armed = 1'b0;
        mmin  = 65535;
        mmax  = 0;
        tick(1'b1);
        repeat (4) tick(1'b0);
        #1 rst_n = 1'b1;
        repeat (3) tick(1'b0);
        s16 = vcnt16;
        wave(4, 4);
        chk("rst_first_rise16", vcnt16, s16);
        chk("rst_busy16", b16, 1);
        wave(4, 4);
        chk("rst_second_rise16", vcnt16, s16 + 1);
        chk("rst_period16", p16, 8);
        chk("rst_min16", mn16, 8);
        chk("rst_max16", mx16, 8);

        // Overflow on the 4-bit instance (period 20), then exactly 15
        chk4 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick((i % 20) < 10, 1'b1, i == 5);
            if (i == 4) s4 = vcnt4;
            if (i == 17) chk("ovf_not_yet4", ov4, 0);
            if (i == 18) begin
                chk("ovf_set4", ov4, 1);
                chk("ovf_busy4", b4, 1);
            end
        end
        chk("ovf_no_sample4", vcnt4, s4);
        chk("ovf_sticky4", ov4, 1);
        wave(8, 7, 1);
        s4 = vcnt4;
        repeat (3) wave(8, 7);
        chk("max_cnt_samples4", vcnt4, s4 + 3);
        chk("max_cnt_period4", p4, 15);
        chk("max_cnt_ovf4", ov4, 0);
        chk("max_cnt_min4", mn4, 15);
        chk("max_cnt_max4", mx4, 15);
        chk("ovf16_clear", ov16, 0);

        repeat (6) tick(1'b0);
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
